// File: rtl/loop_gearshift_ctrl.sv
// loop_gearshift_ctrl
//   Acquisition/track sequencer for the carrier/symbol loop filter. Chooses
//   wide (acquisition) or narrow (tracking) lead/lag gain shifts, zeroes the
//   loop error while the loop is idle or clearing, pulses the integrator
//   clear, and declares lock from the loop error magnitude. FSM and counters
//   advance on clk edges qualified by the loop sample strobe clkEn. The two
//   exceptions are enable=0, which returns to IDLE on any clk, and slip edge
//   capture, which is sampled on every clk.
//
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     clkEn                 loop sample strobe
//     enable                loop run enable
//     errorIn               signed loop error (valid with clkEn)
//     acqLead/acqLag        acquisition gain shifts
//     trkLead/trkLag        tracking gain shifts
//     lockThreshold         "in lock" magnitude threshold (mag <= threshold)
//     lockCount/unlockCount consecutive in/out samples to gain/drop lock
//     zeroErrorReg          force zeroError and freeze the sequencer
//     slipReg               rising edge forces VERIFY/TRACK back to CLEAR
//     lead/lag              active gains to the loop filter
//     zeroError             zero the loop error
//     clearIntegrator       integrator clear
//     locked                lock indication
//     state                 FSM state readback (IDLE=0 .. TRACK=4)
//
//   Optional feature, macro LOOP_ACQ_TIMEOUT_EN:
//     Adds input acqTimeout and output acqTimeoutPulse. The ACQUIRE+VERIFY
//     dwell is counted in samples. When the count reaches acqTimeout
//     (0 = disabled), the FSM returns to CLEAR and a 1-clk pulse is issued.
module loop_gearshift_ctrl #(
  parameter int ERR_WIDTH      = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int CLEAR_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clkEn,
  input  logic                 enable,
  input  logic [ERR_WIDTH-1:0] errorIn,
  input  logic [4:0]           acqLead,
  input  logic [4:0]           acqLag,
  input  logic [4:0]           trkLead,
  input  logic [4:0]           trkLag,
  input  logic [ERR_WIDTH-2:0] lockThreshold,
  input  logic [CNT_WIDTH-1:0] lockCount,
  input  logic [CNT_WIDTH-1:0] unlockCount,
  input  logic                 zeroErrorReg,
  input  logic                 slipReg,
`ifdef LOOP_ACQ_TIMEOUT_EN
  input  logic [CNT_WIDTH-1:0] acqTimeout,
  output logic                 acqTimeoutPulse,
`endif
  output logic [4:0]           lead,
  output logic [4:0]           lag,
  output logic                 zeroError,
  output logic                 clearIntegrator,
  output logic                 locked,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ACQUIRE = 3'd2,
    S_VERIFY  = 3'd3,
    S_TRACK   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CLEAR_LAST   = CNT_WIDTH'(CLEAR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_SAMPLES - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MOST_NEG = {1'b1, {(ERR_WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 slip_prev_q, slip_pend_q, slip_pend_d;
  logic [4:0]           lead_q, lead_d, lag_q, lag_d;
  logic                 zero_error_q, zero_error_d;
  logic                 clear_int_q, clear_int_d;
  logic                 locked_q, locked_d;
  logic                 to_fire;
`ifdef LOOP_ACQ_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                 to_pulse_q;
`endif

  // Error magnitude; the most-negative code has no positive twin and
  // saturates to the largest magnitude instead of wrapping to zero.
  logic [ERR_WIDTH-1:0] err_neg;
  logic [ERR_WIDTH-2:0] err_mag;
  logic                 err_in;
  always_comb begin
    err_neg = ~errorIn + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    if (!errorIn[ERR_WIDTH-1])        err_mag = errorIn[ERR_WIDTH-2:0];
    else if (errorIn == ERR_MOST_NEG) err_mag = '1;
    else                              err_mag = err_neg[ERR_WIDTH-2:0];
    err_in = (err_mag <= lockThreshold);
  end

  // A programmed count of 0 behaves like 1.
  logic [CNT_WIDTH-1:0] lock_lim, unlock_lim, in_inc, out_inc;
  assign lock_lim   = (lockCount == '0) ? CNT_ONE : lockCount;
  assign unlock_lim = (unlockCount == '0) ? CNT_ONE : unlockCount;
  assign in_inc     = (in_cnt_q == '1) ? in_cnt_q : in_cnt_q + CNT_ONE;
  assign out_inc    = (out_cnt_q == '1) ? out_cnt_q : out_cnt_q + CNT_ONE;

  // A slip edge seen between strobes stays pending until the next strobe.
  logic slip_evt, slip_now;
  assign slip_evt = slipReg & ~slip_prev_q;
  assign slip_now = slip_pend_q | slip_evt;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    in_cnt_d     = in_cnt_q;
    settle_cnt_d = settle_cnt_q;
    out_cnt_d    = out_cnt_q;
    slip_pend_d  = slip_pend_q | slip_evt;
    to_fire      = 1'b0;
`ifdef LOOP_ACQ_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    if (!enable) begin
      state_d      = S_IDLE;
      clr_cnt_d    = '0;
      in_cnt_d     = '0;
      settle_cnt_d = '0;
      out_cnt_d    = '0;
      slip_pend_d  = 1'b0;
`ifdef LOOP_ACQ_TIMEOUT_EN
      to_cnt_d     = '0;
`endif
    end else if (clkEn) begin
      slip_pend_d = 1'b0;  // consumed (or ignored) on every sample
      case (state_q)
        S_IDLE: begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
        S_CLEAR: if (!zeroErrorReg) begin
          if (clr_cnt_q == CLEAR_LAST) begin
            state_d   = S_ACQUIRE;
            clr_cnt_d = '0;
            in_cnt_d  = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + CNT_ONE;
          end
        end
        S_ACQUIRE: if (!zeroErrorReg) begin
          if (!err_in) begin
            in_cnt_d = '0;
          end else if (in_inc >= lock_lim) begin
            state_d      = S_VERIFY;
            in_cnt_d     = '0;
            settle_cnt_d = '0;
          end else begin
            in_cnt_d = in_inc;
          end
        end
        S_VERIFY: begin
          if (slip_now) begin
            state_d      = S_CLEAR;
            clr_cnt_d    = '0;
            settle_cnt_d = '0;
          end else if (!zeroErrorReg) begin
            if (!err_in) begin
              state_d      = S_ACQUIRE;
              in_cnt_d     = '0;
              settle_cnt_d = '0;
            end else if (settle_cnt_q == SETTLE_LAST) begin
              state_d      = S_TRACK;
              settle_cnt_d = '0;
              out_cnt_d    = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + CNT_ONE;
            end
          end
        end
        S_TRACK: begin
          // Slip and unlock on the same sample both land in CLEAR.
          if (slip_now) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
            out_cnt_d = '0;
          end else if (!zeroErrorReg) begin
            if (err_in) begin
              out_cnt_d = '0;
            end else if (out_inc >= unlock_lim) begin
              state_d   = S_CLEAR;
              clr_cnt_d = '0;
              out_cnt_d = '0;
            end else begin
              out_cnt_d = out_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
`ifdef LOOP_ACQ_TIMEOUT_EN
      if (state_d == S_TRACK) begin
        to_cnt_d = '0;
      end else if ((state_q == S_ACQUIRE || state_q == S_VERIFY) && !zeroErrorReg) begin
        if (acqTimeout != '0 &&
            ((to_cnt_q == '1) ? to_cnt_q : to_cnt_q + CNT_ONE) >= acqTimeout) begin
          to_fire      = 1'b1;
          state_d      = S_CLEAR;
          clr_cnt_d    = '0;
          in_cnt_d     = '0;
          settle_cnt_d = '0;
          to_cnt_d     = '0;  // re-arm for the next acquisition attempt
        end else begin
          to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + CNT_ONE;
        end
      end
`endif
    end

    // Outputs follow the state being entered, so they move on the same edge.
    lead_d       = (state_d == S_VERIFY || state_d == S_TRACK) ? trkLead : acqLead;
    lag_d        = (state_d == S_VERIFY || state_d == S_TRACK) ? trkLag : acqLag;
    zero_error_d = zeroErrorReg || state_d == S_IDLE || state_d == S_CLEAR;
    clear_int_d  = (state_d == S_CLEAR);
    locked_d     = (state_d == S_TRACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      in_cnt_q     <= '0;
      settle_cnt_q <= '0;
      out_cnt_q    <= '0;
      slip_prev_q  <= 1'b0;
      slip_pend_q  <= 1'b0;
      lead_q       <= '0;
      lag_q        <= '0;
      zero_error_q <= 1'b1;
      clear_int_q  <= 1'b0;
      locked_q     <= 1'b0;
`ifdef LOOP_ACQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      to_pulse_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      in_cnt_q     <= in_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      out_cnt_q    <= out_cnt_d;
      slip_prev_q  <= slipReg;
      slip_pend_q  <= slip_pend_d;
      lead_q       <= lead_d;
      lag_q        <= lag_d;
      zero_error_q <= zero_error_d;
      clear_int_q  <= clear_int_d;
      locked_q     <= locked_d;
`ifdef LOOP_ACQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      to_pulse_q   <= to_fire;
`endif
    end
  end

`ifdef LOOP_ACQ_TIMEOUT_EN
  assign acqTimeoutPulse = to_pulse_q;
`endif
  assign lead            = lead_q;
  assign lag             = lag_q;
  assign zeroError       = zero_error_q;
  assign clearIntegrator = clear_int_q;
  assign locked          = locked_q;
  assign state           = state_q;

endmodule

// File: tb/tb_loop_gearshift_ctrl.sv
// Directed bench for loop_gearshift_ctrl: expected output sets are pushed to
// a queue when each stimulus step is driven and popped/compared after the edge.
module tb_loop_gearshift_ctrl;
  localparam int ERR_WIDTH = 8;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset_n, clkEn, enable, zeroErrorReg, slipReg;
  logic [ERR_WIDTH-1:0] errorIn;
  logic [4:0]           acqLead, acqLag, trkLead, trkLag;
  logic [ERR_WIDTH-2:0] lockThreshold;
  logic [CNT_WIDTH-1:0] lockCount, unlockCount;
  logic [4:0]           lead, lag;
  logic                 zeroError, clearIntegrator, locked;
  logic [2:0]           state;
`ifdef LOOP_ACQ_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] acqTimeout;
  logic                 acqTimeoutPulse;
`endif

  always #5 clk = ~clk;

  loop_gearshift_ctrl #(.ERR_WIDTH(ERR_WIDTH), .CNT_WIDTH(CNT_WIDTH),
                        .CLEAR_CYCLES(4), .SETTLE_SAMPLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .clkEn(clkEn), .enable(enable),
    .errorIn(errorIn), .acqLead(acqLead), .acqLag(acqLag),
    .trkLead(trkLead), .trkLag(trkLag), .lockThreshold(lockThreshold),
    .lockCount(lockCount), .unlockCount(unlockCount),
    .zeroErrorReg(zeroErrorReg), .slipReg(slipReg),
`ifdef LOOP_ACQ_TIMEOUT_EN
    .acqTimeout(acqTimeout), .acqTimeoutPulse(acqTimeoutPulse),
`endif
    .lead(lead), .lag(lag), .zeroError(zeroError),
    .clearIntegrator(clearIntegrator), .locked(locked), .state(state)
  );

  typedef struct {
    logic [2:0] st;
    logic [4:0] lead;
    logic [4:0] lag;
    logic       ze;
    logic       ci;
    logic       lk;
    logic       pulse;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    step   = 0;
  logic  pulse_exp = 1'b0;

  // Error codes used as stimulus (threshold 20 unless changed).
  localparam logic [7:0] E_P15  = 8'h0F;  // +15 in
  localparam logic [7:0] E_N15  = 8'hF1;  // -15 in
  localparam logic [7:0] E_N20  = 8'hEC;  // -20 in (boundary)
  localparam logic [7:0] E_P21  = 8'h15;  // +21 out (boundary)
  localparam logic [7:0] E_P25  = 8'h19;  // +25 out
  localparam logic [7:0] E_N25  = 8'hE7;  // -25 out
  localparam logic [7:0] E_N128 = 8'h80;  // most negative

  // Expected outputs for a given state under the current control inputs.
  function automatic exp_t model(input logic [2:0] st);
    exp_t e;
    logic trk;
    trk     = (st == 3'd3) || (st == 3'd4);
    e.st    = st;
    e.lead  = trk ? trkLead : acqLead;
    e.lag   = trk ? trkLag : acqLag;
    e.ze    = (st == 3'd0) || (st == 3'd1) || zeroErrorReg;
    e.ci    = (st == 3'd1);
    e.lk    = (st == 3'd4);
    e.pulse = pulse_exp;
    return e;
  endfunction

  function automatic exp_t reset_vals();
    exp_t e;
    e.st = 3'd0; e.lead = 5'd0; e.lag = 5'd0;
    e.ze = 1'b1; e.ci = 1'b0; e.lk = 1'b0; e.pulse = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string kind);
    exp_t  e;
    string tag;
    step++;
    tag = $sformatf("%s#%0d", kind, step);
    chk({tag, ".scoreboard_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    $display("%s: state=%0d lead=%0d lag=%0d zeroError=%0b clearInt=%0b locked=%0b err=%0d",
             tag, state, lead, lag, zeroError, clearIntegrator, locked, $signed(errorIn));
    chk({tag, ".state"}, 32'(state), 32'(e.st));
    chk({tag, ".lead"}, 32'(lead), 32'(e.lead));
    chk({tag, ".lag"}, 32'(lag), 32'(e.lag));
    chk({tag, ".zeroError"}, 32'(zeroError), 32'(e.ze));
    chk({tag, ".clearIntegrator"}, 32'(clearIntegrator), 32'(e.ci));
    chk({tag, ".locked"}, 32'(locked), 32'(e.lk));
`ifdef LOOP_ACQ_TIMEOUT_EN
    chk({tag, ".acqTimeoutPulse"}, 32'(acqTimeoutPulse), 32'(e.pulse));
`endif
  endtask

  // One clk with no sample strobe, then check the expected state.
  task automatic tick_expect(input logic [2:0] st);
    clkEn = 1'b0;
    sb.push_back(model(st));
    @(posedge clk); #1;
    compare_out("tick");
  endtask

  task automatic strobe_now(input logic [7:0] e, input logic [2:0] st);
    errorIn = e;
    clkEn   = 1'b1;
    sb.push_back(model(st));
    @(posedge clk); #1;
    clkEn = 1'b0;
    compare_out("sample");
  endtask

  // clkEn once every 4 clks.
  task automatic strobe(input logic [7:0] e, input logic [2:0] st);
    clkEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    strobe_now(e, st);
  endtask

  function automatic logic [7:0] in_err(input int i);
    return (i % 2 == 1) ? E_N15 : E_P15;
  endfunction

  // Three more CLEAR samples, then the move to ACQUIRE.
  task automatic run_clear();
    for (int i = 0; i < 3; i++) strobe(in_err(i), 3'd1);
    strobe(E_P15, 3'd2);
  endtask

  // From a fresh ACQUIRE (lockCount 8): lock, settle 64, reach TRACK.
  task automatic lock_up();
    for (int i = 0; i < 7; i++) strobe(in_err(i), 3'd2);
    strobe(E_P15, 3'd3);
    for (int i = 0; i < 63; i++) strobe(in_err(i), 3'd3);
    strobe(E_N15, 3'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clkEn = 1'b0; enable = 1'b0; errorIn = '0;
    acqLead = 5'd12; acqLag = 5'd10; trkLead = 5'd16; trkLag = 5'd14;
    lockThreshold = 7'd20; lockCount = 16'd8; unlockCount = 16'd3;
    zeroErrorReg = 1'b0; slipReg = 1'b0;
`ifdef LOOP_ACQ_TIMEOUT_EN
    acqTimeout = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(reset_vals());
    compare_out("reset");

    reset_n = 1'b1;
    tick_expect(3'd0);                // IDLE drives acquisition gains

    // Start: CLEAR for 4 samples, then ACQUIRE.
    enable = 1'b1;
    strobe(E_P15, 3'd1);
    run_clear();

    // 7 in then 1 out restarts the count; -20 sits exactly on the threshold.
    for (int i = 0; i < 7; i++) strobe(in_err(i), 3'd2);
    strobe(E_P21, 3'd2);
    strobe(E_N20, 3'd2);
    for (int i = 0; i < 6; i++) strobe(in_err(i), 3'd2);
    strobe(E_P15, 3'd3);

    // One most-negative sample in VERIFY drops back to ACQUIRE.
    for (int i = 0; i < 63; i++) strobe(in_err(i), 3'd3);
    strobe(E_N128, 3'd2);

    // With threshold 127 the most-negative code saturates to 127 and is "in".
    lockThreshold = 7'd127;
    for (int i = 0; i < 7; i++) strobe(E_N128, 3'd2);
    strobe(E_N128, 3'd3);
    lockThreshold = 7'd20;
    for (int i = 0; i < 63; i++) strobe(in_err(i), 3'd3);
    strobe(E_P15, 3'd4);

    // TRACK unlock with unlockCount 3: out,out,in,out,out,out.
    strobe(E_P25, 3'd4);
    strobe(E_N25, 3'd4);
    strobe(E_P15, 3'd4);
    strobe(E_P25, 3'd4);
    strobe(E_N25, 3'd4);
    strobe(E_P25, 3'd1);
    run_clear();
    lock_up();

    // Slip pulse between strobes is held and acted on at the next strobe.
    slipReg = 1'b1;
    tick_expect(3'd4);
    slipReg = 1'b0;
    tick_expect(3'd4);
    tick_expect(3'd4);
    strobe_now(E_P15, 3'd1);
    run_clear();

    // zeroErrorReg forces zeroError and freezes the lock count at 7.
    for (int i = 0; i < 7; i++) strobe(in_err(i), 3'd2);
    zeroErrorReg = 1'b1;
    tick_expect(3'd2);
    for (int i = 0; i < 3; i++) strobe(in_err(i), 3'd2);
    zeroErrorReg = 1'b0;
    strobe(E_P15, 3'd3);
    for (int i = 0; i < 63; i++) strobe(in_err(i), 3'd3);
    strobe(E_N15, 3'd4);

    // Dropping enable returns to IDLE on the next clk without a strobe.
    enable = 1'b0;
    tick_expect(3'd0);
    enable = 1'b1;
    strobe(E_P15, 3'd1);
    run_clear();

`ifdef LOOP_ACQ_TIMEOUT_EN
    acqTimeout = 16'd100;
    for (int i = 0; i < 99; i++) strobe(E_P25, 3'd2);
    pulse_exp = 1'b1;
    strobe(E_P25, 3'd1);
    pulse_exp = 1'b0;
    tick_expect(3'd1);
    run_clear();
    acqTimeout = '0;
    for (int i = 0; i < 150; i++) strobe(E_P25, 3'd2);
`endif

    // lockCount 0 behaves as 1; tracking gain change shows up one clk later.
    lockCount = '0;
    strobe(E_P15, 3'd3);
    trkLead = 5'd9;
    tick_expect(3'd3);
    trkLead = 5'd16;

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    reset_n = 1'b0;
    #1;
    sb.push_back(reset_vals());
    compare_out("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
